// File: rtl/sample_uart_logger.sv
// sample_uart_logger: buffers 8-bit samples in a small FIFO and streams each
// one out as an 8N1 UART byte (LSB first), flagging and counting overflow drops.
//
// Ports:
//   CLK_50MHz     - sole clock, rising edge
//   RESET         - asynchronous active-low reset
//   Sample_word   - 8-bit sample, valid while Sample_strobe is high
//   Sample_strobe - one-cycle pulse announcing a new sample
//   Enable        - when low, strobes are ignored (FIFO keeps draining)
//   TX            - UART serial output, idle high, registered
//   Busy          - FSM not idle or FIFO non-empty, registered
//   Fifo_count    - FIFO occupancy 0..2^FIFO_AW, registered
//   Overflow      - sticky flag, set on first dropped sample
//   Drop_count    - dropped-sample counter, saturates at 255
module sample_uart_logger #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               CLK_50MHz,
  input  logic               RESET,
  input  logic [7:0]         Sample_word,
  input  logic               Sample_strobe,
  input  logic               Enable,
  output logic               TX,
  output logic               Busy,
  output logic [FIFO_AW:0]   Fifo_count,
  output logic               Overflow,
  output logic [7:0]         Drop_count
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CW     = FIFO_AW + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q;
  logic [7:0]          drop_q;

  logic full_c, empty_c, pop_c, accept_c, push_c, drop_c, baud_done_c;

  // FIFO control: a pop on the same edge frees a slot for a write when full
  assign full_c      = (count_q == CW'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign pop_c       = (state_q == S_IDLE) && !empty_c;
  assign accept_c    = Sample_strobe && Enable;
  assign push_c      = accept_c && (!full_c || pop_c);
  assign drop_c      = accept_c && full_c && !pop_c;
  assign baud_done_c = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (!push_c && pop_c) count_d = count_q - CW'(1);
  end

  // FIFO storage (no reset needed; contents are qualified by count)
  always_ff @(posedge CLK_50MHz) begin
    if (push_c) mem_q[wr_ptr_q] <= Sample_word;
  end

  // FIFO pointers and overflow status
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // TX FSM state register
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // TX FSM next state; baud counter wraps at every bit boundary
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        if (pop_c) begin
          state_d = S_START;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      S_START: begin
        if (baud_done_c) begin
          state_d = S_DATA;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_done_c) begin
          baud_d = '0;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_done_c) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  assign TX         = tx_q;
  assign Busy       = busy_q;
  assign Fifo_count = count_q;
  assign Overflow   = overflow_q;
  assign Drop_count = drop_q;

endmodule
